serial_adder_ctrl: RTL and testbench
====================================

Name: serial_adder_ctrl

Overview:
Bit-serial multi-bit adder built around the existing one-bit full_adder_v cell. Accepts two WIDTH-bit operands plus carry-in over a valid/ready handshake. Feeds one operand bit pair per clock, LSB first, into the full adder, with a registered carry loop. Returns the WIDTH-bit sum and final carry-out over a valid/ready handshake. Sits directly upstream of full_adder_v and drives its a, b and c_in pins every cycle.

Parameters:
WIDTH, 8, operand/sum width in bits; legal range 1..64.

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  synchronous active-low reset
in_valid  input  1  operand request
in_ready  output  1  block can accept operands; high only in IDLE
a  input  WIDTH  operand A, sampled on accept
b  input  WIDTH  operand B, sampled on accept
c_in  input  1  carry-in, sampled on accept
sub  input  1  subtract request, sampled on accept; present only with SERIAL_ADDER_SUB_EN
out_valid  output  1  result valid; high only in DONE
out_ready  input  1  downstream accepts result
sum  output  WIDTH  result word
c_out  output  1  final carry-out
busy  output  1  high in RUN or DONE

Behaviour:
- Reset: clk and rst_n are the only clock and reset. Reset is synchronous and active-low: at a rising clk edge with rst_n=0, the block returns to IDLE. Reset values: out_valid=0, busy=0, sum=0, c_out=0, carry register=0, bit counter=0, shift registers=0. in_ready=1 from the first edge after reset is released.
- FSM states: IDLE, RUN, DONE. in_ready, out_valid and busy are decoded from the state register only, with no combinational path from the inputs.
- IDLE: on in_valid and in_ready at an edge, load a_sh<=a, b_sh<=b, carry<=c_in, cnt<=0, and go to RUN.
- RUN, each cycle:
  - The full adder receives a_sh[0], b_sh[0] and carry.
  - sum_sh <= {fa_sum, sum_sh[WIDTH-1:1]}.
  - a_sh and b_sh shift right by one.
  - carry <= fa_c_out; cnt <= cnt+1.
  - When cnt==WIDTH-1, go to DONE.
- DONE: sum=sum_sh and c_out=carry, both held stable until the handshake. On out_valid and out_ready, go to IDLE.
- Latency: out_valid rises exactly WIDTH cycles after the accept edge. Minimum issue interval is WIDTH+2 cycles.
- in_valid outside IDLE is ignored, with no state change. Operands may change freely after the accept edge.
- WIDTH=1: a single RUN cycle, then DONE. The counter is max($clog2(WIDTH),1) bits wide.
- Carry wrap: the final carry goes only to c_out. Carry never wraps into bit 0.
- Reset mid-RUN or mid-DONE: the operation is discarded, no out_valid pulse, and the block is in IDLE on the next edge.
- Simultaneous rst_n=0 with any handshake: reset wins.

Optional Feature:
SERIAL_ADDER_SUB_EN
- Defined: the sub port exists. On accept with sub=1, the block loads b_sh<=~b and carry<=1, ignoring c_in. The result is a-b. c_out=1 means no borrow.
- Undefined: no sub port; add only.

Decomposition:
- Shared package serial_adder_pkg holds:
  - state encoding constants ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2
  - the default WIDTH constant
- The one sub-module is full_adder_v, instantiated once as the bit-slice datapath. It is reused unchanged.

Test Plan:
1. rst_n low for 3 edges, with in_valid=1 -> out_valid=0, sum=0, c_out=0, busy=0 throughout. in_ready=1 on the first cycle after release.
2. WIDTH=8, a=0x05, b=0x03, c_in=0 -> out_valid exactly 8 cycles after accept; sum=0x08, c_out=0.
3. a=0xFF, b=0x01, c_in=0 -> sum=0x00, c_out=1. Then a=0xFF, b=0xFF, c_in=1 -> sum=0xFF, c_out=1.
4. Result ready with out_ready held low for 5 cycles while in_valid pulses with new operands -> sum, c_out and out_valid stable, in_ready=0, new operands ignored. Then the handshake completes and the block is back in IDLE.
5. rst_n low for one edge while cnt=3 in RUN -> IDLE next cycle, no out_valid for that operation. A following 0x10+0x20 gives sum=0x30, c_out=0.
6. With SERIAL_ADDER_SUB_EN: sub=1, a=0x05, b=0x03 -> sum=0x02, c_out=1. Then sub=1, a=0x03, b=0x05 -> sum=0xFE, c_out=0.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared state encoding and default width for serial_adder_ctrl.
package serial_adder_pkg;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;
  localparam int DEFAULT_WIDTH = 8;
endpackage

// File: rtl/serial_adder_ctrl_if.sv
// serial_adder_ctrl_if: operand/result handshake bundle; sub exists only with SERIAL_ADDER_SUB_EN.
interface serial_adder_ctrl_if import serial_adder_pkg::*; #(parameter int WIDTH = DEFAULT_WIDTH);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
`ifdef SERIAL_ADDER_SUB_EN
  logic             sub;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             c_out;
  logic             busy;
  modport slave (
`ifdef SERIAL_ADDER_SUB_EN
    input  sub,
`endif
    input  in_valid, a, b, c_in, out_ready,
    output in_ready, out_valid, sum, c_out, busy
  );
  modport master (
`ifdef SERIAL_ADDER_SUB_EN
    output sub,
`endif
    output in_valid, a, b, c_in, out_ready,
    input  in_ready, out_valid, sum, c_out, busy
  );
endinterface

// File: rtl/full_adder_v.sv
// full_adder_v: one-bit full adder cell used as the serial datapath slice.
module full_adder_v (
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic sum,
  output logic c_out
);
  assign sum   = a ^ b ^ c_in;
  assign c_out = (a & b) | (c_in & (a ^ b));
endmodule

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial WIDTH-bit adder around full_adder_v, LSB first.
// SERIAL_ADDER_SUB_EN adds a subtract mode (a + ~b + 1) selected by bus.sub.
module serial_adder_ctrl import serial_adder_pkg::*; #(parameter int WIDTH = DEFAULT_WIDTH) (
  input logic clk,
  input logic rst_n,
  serial_adder_ctrl_if.slave bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d, b_sh_q, b_sh_d, sum_sh_q, sum_sh_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d, fa_sum, fa_c_out, sub_w;
`ifdef SERIAL_ADDER_SUB_EN
  assign sub_w = bus.sub;
`else
  assign sub_w = 1'b0;
`endif
  full_adder_v u_fa (
    .a     (a_sh_q[0]),
    .b     (b_sh_q[0]),
    .c_in  (carry_q),
    .sum   (fa_sum),
    .c_out (fa_c_out)
  );
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      sum_sh_q <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      sum_sh_q <= sum_sh_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
    end
  end
  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    sum_sh_d = sum_sh_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    case (state_q)
      ST_IDLE: if (bus.in_valid) begin
        a_sh_d  = bus.a;
        b_sh_d  = sub_w ? ~bus.b : bus.b;
        carry_d = sub_w ? 1'b1 : bus.c_in;
        cnt_d   = '0;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        // concatenate then shift so the WIDTH=1 case needs no special slice
        sum_sh_d = WIDTH'({fa_sum, sum_sh_q} >> 1);
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        carry_d  = fa_c_out;
        cnt_d    = cnt_q + CW'(1);
        state_d  = (cnt_q == CW'(WIDTH - 1)) ? ST_DONE : ST_RUN;
      end
      ST_DONE: state_d = bus.out_ready ? ST_IDLE : ST_DONE;
      default: state_d = ST_IDLE;
    endcase
  end
  assign bus.in_ready  = state_q == ST_IDLE;
  assign bus.out_valid = state_q == ST_DONE;
  assign bus.busy      = state_q != ST_IDLE;
  assign bus.sum       = (state_q == ST_DONE) ? sum_sh_q : '0;
  assign bus.c_out     = (state_q == ST_DONE) && carry_q;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl: scoreboard bench for serial_adder_ctrl (WIDTH=8).
module tb_serial_adder_ctrl;
  localparam int W = 8;
  typedef struct {
    logic [W-1:0] s;
    logic         c;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;
  exp_t sb[$];
  serial_adder_ctrl_if #(.WIDTH(W)) bus ();
  serial_adder_ctrl #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin, input logic sub);
    logic [W:0] r;
    exp_t e;
    r = sub ? ({1'b0, a} - {1'b0, b} + (W+1)'(1 << W)) : ({1'b0, a} + {1'b0, b} + (W+1)'(cin));
    e.s = r[W-1:0];
    e.c = r[W];
    return e;
  endfunction
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin, input logic sub);
    int n = 0;
    bus.a = a;
    bus.b = b;
    bus.c_in = cin;
`ifdef SERIAL_ADDER_SUB_EN
    bus.sub = sub;
`endif
    bus.in_valid = 1'b1;
    while (!bus.in_ready && n < 50) begin
      step();
      n++;
    end
    tests++;
    if (bus.in_ready !== 1'b1) begin
      fails++;
      $display("FAIL issue_ready: in_ready=%b required 1", bus.in_ready);
    end
    step();
    bus.in_valid = 1'b0;
    bus.a = $urandom;
    bus.b = $urandom;
    bus.c_in = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
    sb.push_back(model(a, b, cin, sub));
`else
    sb.push_back(model(a, b, cin, 1'b0));
`endif
    tests++;
    if (bus.busy !== 1'b1 || bus.in_ready !== 1'b0) begin
      fails++;
      $display("FAIL accept: busy=%b in_ready=%b required 1/0", bus.busy, bus.in_ready);
    end
  endtask
  task automatic receive(input int hold);
    int lat = 0;
    exp_t e;
    for (int k = 1; k <= 3 * W; k++) begin
      step();
      if (bus.out_valid === 1'b1) begin
        lat = k;
        break;
      end
    end
    tests++;
    if (lat != W) begin
      fails++;
      $display("FAIL latency: got %0d cycles required %0d", lat, W);
    end
    if (sb.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL scoreboard: empty queue at result");
      return;
    end
    e = sb[0];
    tests++;
    if (bus.sum !== e.s || bus.c_out !== e.c) begin
      fails++;
      $display("FAIL result: sum=%h c_out=%b required sum=%h c_out=%b", bus.sum, bus.c_out, e.s, e.c);
    end
    for (int i = 0; i < hold; i++) begin
      bus.in_valid = ~i[0];
      bus.a = $urandom;
      bus.b = $urandom;
      bus.c_in = $urandom;
      step();
      tests++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.sum !== e.s || bus.c_out !== e.c) begin
        fails++;
        $display("FAIL stall_hold: out_valid=%b in_ready=%b sum=%h c_out=%b required 1/0/%h/%b",
                 bus.out_valid, bus.in_ready, bus.sum, bus.c_out, e.s, e.c);
      end
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    void'(sb.pop_front());
    tests++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
      fails++;
      $display("FAIL release: out_valid=%b in_ready=%b busy=%b required 0/1/0", bus.out_valid, bus.in_ready, bus.busy);
    end
  endtask
  task automatic test_reset();
    rst_n = 1'b0;
    bus.in_valid = 1'b1;
    bus.a = 8'hAA;
    bus.b = 8'h55;
    bus.c_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      tests++;
      if (bus.out_valid !== 1'b0 || bus.sum !== '0 || bus.c_out !== 1'b0 || bus.busy !== 1'b0) begin
        fails++;
        $display("FAIL reset_hold: out_valid=%b sum=%h c_out=%b busy=%b required 0/00/0/0",
                 bus.out_valid, bus.sum, bus.c_out, bus.busy);
      end
    end
    bus.in_valid = 1'b0;
    rst_n = 1'b1;
    step();
    tests++;
    if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_release: in_ready=%b busy=%b required 1/0", bus.in_ready, bus.busy);
    end
  endtask
  task automatic test_basic();
    issue(8'h05, 8'h03, 1'b0, 1'b0);
    receive(0);
  endtask
  task automatic test_carry();
    issue(8'hFF, 8'h01, 1'b0, 1'b0);
    receive(0);
    issue(8'hFF, 8'hFF, 1'b1, 1'b0);
    receive(0);
  endtask
  task automatic test_stall();
    issue(8'h5A, 8'hC3, 1'b1, 1'b0);
    receive(5);
    issue(8'h01, 8'h02, 1'b0, 1'b0);
    receive(0);
  endtask
  task automatic test_reset_mid();
    int seen = 0;
    issue(8'h11, 8'h22, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    void'(sb.pop_front());
    tests++;
    if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid: in_ready=%b busy=%b out_valid=%b required 1/0/0", bus.in_ready, bus.busy, bus.out_valid);
    end
    for (int i = 0; i < 2 * W; i++) begin
      step();
      if (bus.out_valid === 1'b1) seen++;
    end
    tests++;
    if (seen != 0) begin
      fails++;
      $display("FAIL reset_mid_quiet: out_valid high %0d cycles required 0", seen);
    end
    issue(8'h10, 8'h20, 1'b0, 1'b0);
    receive(0);
  endtask
  task automatic test_back_to_back();
    for (int i = 0; i < 16; i++) begin
`ifdef SERIAL_ADDER_SUB_EN
      issue(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
`else
      issue(W'($urandom), W'($urandom), 1'($urandom), 1'b0);
`endif
      receive(i % 3);
    end
  endtask
`ifdef SERIAL_ADDER_SUB_EN
  task automatic test_sub();
    issue(8'h05, 8'h03, 1'b0, 1'b1);
    receive(0);
    issue(8'h03, 8'h05, 1'b1, 1'b1);
    receive(0);
    bus.sub = 1'b0;
  endtask
`endif
  initial begin
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.c_in = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
    bus.sub = 1'b0;
`endif
    test_reset();
    test_basic();
    test_carry();
    test_stall();
    test_reset_mid();
`ifdef SERIAL_ADDER_SUB_EN
    test_sub();
`endif
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
